// File: rtl/button_pio_pkg.sv
// Shared register map and reset constants for the button PIO block.
package button_pio_pkg;

    localparam logic [2:0] REG_DATA     = 3'd0;
    localparam logic [2:0] REG_RISE_EN  = 3'd1;
    localparam logic [2:0] REG_IRQ_MASK = 3'd2;
    localparam logic [2:0] REG_EDGE_CAP = 3'd3;
    localparam logic [2:0] REG_FALL_EN  = 3'd4;
    localparam logic [2:0] REG_DEBOUNCE = 3'd5;
    localparam logic [2:0] REG_PENDING  = 3'd6;

    localparam logic [31:0] RESET_FALL_EN = 32'hFFFF_FFFF;

endpackage

// File: rtl/button_pio_debounce.sv
// One-channel debounce filter: filt_o follows sync2_i only after it has differed for
// debounce_i consecutive cycles.
module button_pio_debounce
    import button_pio_pkg::*;
#(
    parameter int unsigned DB_CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sync2_i,
    input  logic [DB_CNT_W-1:0] debounce_i,
    output logic                filt_o
);

    logic                filt_q, filt_d;
    logic [DB_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (sync2_i == filt_q) begin
            cnt_d = '0;
        // >= rather than == so a DEBOUNCE lowered mid-count still fires instead of stalling.
        end else if (debounce_i <= DB_CNT_W'(1) || cnt_q >= debounce_i - 1'b1) begin
            filt_d = sync2_i;
            cnt_d  = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/button_pio_irq.sv
// Avalon-MM PIO input block with per-bit edge capture and level IRQ.
// Define BUTTON_PIO_DEBOUNCE_EN to add a per-channel debounce filter and DEBOUNCE register.
module button_pio_irq
    import button_pio_pkg::*;
#(
    parameter int unsigned          WIDTH    = 8,
    parameter int unsigned          DB_CNT_W = 16,
    parameter logic [DB_CNT_W-1:0]  DB_RESET = 16'd50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             chipselect,
    input  logic [2:0]       address,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [WIDTH-1:0] mask_q, mask_d, cap_q, cap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] filt, edges, wdata;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

`ifdef BUTTON_PIO_DEBOUNCE_EN
    logic [DB_CNT_W-1:0] debounce_q, debounce_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        button_pio_debounce #(
            .DB_CNT_W(DB_CNT_W)
        ) u_db (
            .clk       (clk),
            .reset_n   (reset_n),
            .sync2_i   (sync2_q[i]),
            .debounce_i(debounce_q),
            .filt_o    (filt[i])
        );
    end

    always_comb begin
        debounce_d = debounce_q;
        if (wr_en && address == REG_DEBOUNCE) begin
            debounce_d = writedata[DB_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            debounce_q <= DB_RESET;
        end else begin
            debounce_q <= debounce_d;
        end
    end
`else
    // Without the filter, the second synchroniser stage is the filtered level.
    assign filt = sync2_q;
`endif

    assign edges = (filt & ~prev_q & rise_en_q) | (~filt & prev_q & fall_en_q);

    always_comb begin
        sync1_d   = in_port;
        sync2_d   = sync1_q;
        prev_d    = filt;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        mask_d    = mask_q;
        cap_d     = cap_q;
        if (wr_en) begin
            case (address)
                REG_RISE_EN:  rise_en_d = wdata;
                REG_IRQ_MASK: mask_d    = wdata;
                REG_FALL_EN:  fall_en_d = wdata;
                REG_EDGE_CAP: cap_d     = cap_q & ~wdata;
                default:      ;
            endcase
        end
        // A new edge overrides a same-cycle clear.
        cap_d = cap_d | edges;

        readdata_d = '0;
        case (address)
            REG_DATA:     readdata_d[WIDTH-1:0] = filt;
            REG_RISE_EN:  readdata_d[WIDTH-1:0] = rise_en_q;
            REG_IRQ_MASK: readdata_d[WIDTH-1:0] = mask_q;
            REG_EDGE_CAP: readdata_d[WIDTH-1:0] = cap_q;
            REG_FALL_EN:  readdata_d[WIDTH-1:0] = fall_en_q;
`ifdef BUTTON_PIO_DEBOUNCE_EN
            REG_DEBOUNCE: readdata_d[DB_CNT_W-1:0] = debounce_q;
`endif
            REG_PENDING:  readdata_d[WIDTH-1:0] = cap_q & mask_q;
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= RESET_FALL_EN[WIDTH-1:0];
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_button_pio_irq.sv
// Scoreboard bench for button_pio_irq: stimulus queues expectations, a monitor compares.
module tb_button_pio_irq;
    import button_pio_pkg::*;

`ifdef BUTTON_PIO_DEBOUNCE_EN
    localparam int          LAT      = 1;
    localparam logic [31:0] DB_EXP   = 32'd50000;
    localparam logic [31:0] DATA_RST = 32'h0;
`else
    localparam int          LAT      = 0;
    localparam logic [31:0] DB_EXP   = 32'h0;
    localparam logic [31:0] DATA_RST = 32'hFF;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        chipselect = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [7:0]  in_port = 8'h0;
    logic [31:0] readdata;
    logic        irq;

    button_pio_irq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .chipselect(chipselect),
        .address   (address),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          is_irq;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    exp_t        push_e;
    exp_t        mon_e;
    logic [31:0] mon_act;
    logic        chk_req = 1'b0;
    logic        chk_v = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    // Output for a request issued before posedge k is presented at the following negedge.
    always @(posedge clk) chk_v <= chk_req;

    always @(negedge clk) begin
        if (chk_v) begin
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL sb_empty: output presented with no expectation queued");
            end else begin
                mon_e   = sb.pop_front();
                mon_act = mon_e.is_irq ? {31'b0, irq} : readdata;
                n_checks++;
                if (mon_act !== mon_e.exp) begin
                    n_errors++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h", mon_e.name, mon_act, mon_e.exp);
                end
            end
        end
    end

    task automatic expect_push(input string n, input bit is_irq, input logic [31:0] e);
        push_e.name   = n;
        push_e.is_irq = is_irq;
        push_e.exp    = e;
        sb.push_back(push_e);
    endtask

    task automatic check_rd(input logic [2:0] a, input logic [31:0] e, input string n);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        expect_push(n, 1'b0, e);
        chk_req = 1'b1;
        @(negedge clk);
        chk_req    = 1'b0;
        chipselect = 1'b0;
    endtask

    // Samples irq after the next rising edge.
    task automatic check_irq(input logic e, input string n);
        expect_push(n, 1'b1, {31'b0, e});
        chk_req = 1'b1;
        @(negedge clk);
        chk_req = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        // Reset with inputs high
        reset_n = 1'b0;
        in_port = 8'hFF;
        @(negedge clk);
        check_rd(REG_FALL_EN, 32'h0, "rd_in_reset");
        reset_n = 1'b1;
        check_irq(1'b0, "irq_after_reset");
        check_rd(REG_FALL_EN, 32'hFF, "fall_en_rst");
        check_rd(REG_RISE_EN, 32'h0, "rise_en_rst");
        check_rd(REG_IRQ_MASK, 32'h0, "mask_rst");
        check_rd(REG_EDGE_CAP, 32'h0, "cap_rst");
        check_rd(REG_DEBOUNCE, DB_EXP, "debounce_rst");
        check_rd(REG_PENDING, 32'h0, "pending_rst");
        check_rd(3'd7, 32'h0, "reserved_rd");
        check_rd(REG_DATA, DATA_RST, "data_after_rst");
        wr(REG_DATA, 32'h0);
        check_rd(REG_DATA, DATA_RST, "data_wr_ignored");
`ifdef BUTTON_PIO_DEBOUNCE_EN
        wr(REG_DEBOUNCE, 32'h0);
        repeat (3) @(negedge clk);
        check_rd(REG_DEBOUNCE, 32'h0, "debounce_wr");
        check_rd(REG_DATA, 32'hFF, "data_unfiltered");
`else
        wr(REG_DEBOUNCE, 32'h1234);
        check_rd(REG_DEBOUNCE, 32'h0, "debounce_wr_ignored");
`endif

        // Falling edge on bit 0 with exact pin-to-capture latency
        wr(REG_IRQ_MASK, 32'h01);
        in_port = 8'hFE;
        @(negedge clk);
        for (int i = 0; i <= LAT; i++) check_irq(1'b0, "irq_before_capture");
        check_irq(1'b1, "irq_on_fall");
        check_rd(REG_EDGE_CAP, 32'h01, "cap_fall");
        check_rd(REG_PENDING, 32'h01, "pending_fall");
        wr(REG_EDGE_CAP, 32'h01);
        check_irq(1'b0, "irq_after_w1c");
        check_rd(REG_EDGE_CAP, 32'h0, "cap_after_w1c");

        // Rising-only capture on bit 2
        wr(REG_RISE_EN, 32'h04);
        wr(REG_FALL_EN, 32'h00);
        in_port = 8'hFA;
        repeat (5) @(negedge clk);
        in_port = 8'hFE;
        repeat (3) @(negedge clk);
        in_port = 8'hFA;
        repeat (5) @(negedge clk);
        check_rd(REG_EDGE_CAP, 32'h04, "cap_rise_only");
        check_irq(1'b0, "irq_masked_rise");
        check_rd(REG_PENDING, 32'h0, "pending_masked");
        wr(REG_IRQ_MASK, 32'h04);
        check_irq(1'b1, "irq_unmasked_rise");
        check_rd(REG_PENDING, 32'h04, "pending_rise");
        wr(REG_EDGE_CAP, 32'hFF);
        check_rd(REG_EDGE_CAP, 32'h0, "cap_clear_all");

        // W1C in the same cycle a falling edge on bit 1 is captured
        wr(REG_RISE_EN, 32'h00);
        wr(REG_FALL_EN, 32'h02);
        wr(REG_IRQ_MASK, 32'h02);
        in_port = 8'hF8;
        repeat (2 + LAT) @(negedge clk);
        wr(REG_EDGE_CAP, 32'h02);
        check_rd(REG_EDGE_CAP, 32'h02, "w1c_collision");
        check_irq(1'b1, "irq_collision");
        wr(REG_EDGE_CAP, 32'h02);
        check_rd(REG_EDGE_CAP, 32'h0, "cap_clear_bit1");

`ifdef BUTTON_PIO_DEBOUNCE_EN
        // Bouncing bit 3 with DEBOUNCE=10: one capture 12-13 cycles after the last transition
        wr(REG_FALL_EN, 32'h08);
        wr(REG_IRQ_MASK, 32'h08);
        wr(REG_DEBOUNCE, 32'd10);
        wr(REG_EDGE_CAP, 32'hFF);
        for (int i = 0; i <= 10; i++) begin
            in_port[3] = (i % 2 == 1);
            if (i < 10) repeat (4) @(negedge clk);
        end
        repeat (11) @(negedge clk);
        check_irq(1'b0, "db_irq_cycle12");
        check_irq(1'b1, "db_irq_cycle13");
        check_rd(REG_EDGE_CAP, 32'h08, "db_cap_single");
        check_rd(REG_PENDING, 32'h08, "db_pending");
        wr(REG_IRQ_MASK, 32'h00);
        check_rd(REG_PENDING, 32'h0, "db_pending_masked");
        check_rd(REG_EDGE_CAP, 32'h08, "db_cap_kept");

        // Reset at count 5 of 10 while bit 3 rises
        in_port = 8'hF8;
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check_rd(REG_DATA, 32'h0, "mid_reset_filt");
        check_rd(REG_EDGE_CAP, 32'h0, "mid_reset_cap");
        check_irq(1'b0, "mid_reset_irq");
        wr(REG_DEBOUNCE, 32'd10);
        wr(REG_RISE_EN, 32'h08);
        wr(REG_IRQ_MASK, 32'h08);
        repeat (20) @(negedge clk);
        check_rd(REG_EDGE_CAP, 32'h08, "post_reset_rise");
        check_irq(1'b1, "post_reset_irq");
        check_rd(REG_DATA, 32'hF8, "post_reset_data");
`endif

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
